// File: rtl/serial_rx_if.sv
// rtl/serial_rx_if.sv - serial_rx pin and received-byte bundle
interface serial_rx_if;
   logic       rx;
   logic [7:0] data;
   logic       new_data;
   logic       frame_err;
   logic       busy;

   modport master (
      input  rx,
      output data, new_data, frame_err, busy
   );

   modport slave (
      output rx,
      input  data, new_data, frame_err, busy
   );
endinterface

// File: rtl/serial_rx.sv
// rtl/serial_rx.sv - 8N1 LSB-first UART receiver with mid-bit sampling
module serial_rx #(
   parameter int CLK_PER_BIT = 50,
   parameter int CTR_SIZE    = $clog2(CLK_PER_BIT)
) (
   input  logic       clk,
   input  logic       rst,
   serial_rx_if.master bus
);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START_BIT = 3'd1,
      DATA      = 3'd2,
      STOP_BIT  = 3'd3,
      WAIT_HIGH = 3'd4
   } state_t;

   localparam logic [CTR_SIZE-1:0] CTR_LAST = CTR_SIZE'(CLK_PER_BIT - 1);
   localparam logic [CTR_SIZE-1:0] CTR_HALF = CTR_SIZE'(CLK_PER_BIT / 2 - 1);

   state_t              state_q, state_d;
   logic [CTR_SIZE-1:0] ctr_q, ctr_d;
   logic [2:0]          bit_ctr_q, bit_ctr_d;
   logic [7:0]          shift_q, shift_d;
   logic [7:0]          data_q;
   logic                new_data_q, frame_err_q;
   logic                rx_meta, rx_s;
   logic                new_data_set, frame_err_set, busy;

   // Synchroniser flops reset high so a reset never looks like a start bit.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_meta     <= 1'b1;
         rx_s        <= 1'b1;
         state_q     <= IDLE;
         ctr_q       <= '0;
         bit_ctr_q   <= '0;
         shift_q     <= '0;
         data_q      <= 8'h00;
         new_data_q  <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         rx_meta     <= bus.rx;
         rx_s        <= rx_meta;
         state_q     <= state_d;
         ctr_q       <= ctr_d;
         bit_ctr_q   <= bit_ctr_d;
         shift_q     <= shift_d;
         new_data_q  <= new_data_set;
         frame_err_q <= frame_err_set;
         if (new_data_set) begin
            data_q <= shift_q;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      ctr_d     = ctr_q;
      bit_ctr_d = bit_ctr_q;
      shift_d   = shift_q;
      case (state_q)
         IDLE: begin
            ctr_d     = '0;
            bit_ctr_d = '0;
            if (!rx_s) begin
               state_d = START_BIT;
            end
         end
         START_BIT: begin
            ctr_d = ctr_q + CTR_SIZE'(1);
            if (ctr_q == CTR_HALF) begin
               ctr_d   = '0;
               state_d = rx_s ? IDLE : DATA;
            end
         end
         DATA: begin
            ctr_d = ctr_q + CTR_SIZE'(1);
            if (ctr_q == CTR_LAST) begin
               ctr_d              = '0;
               shift_d[bit_ctr_q] = rx_s;
               bit_ctr_d          = bit_ctr_q + 3'd1;
               if (bit_ctr_q == 3'd7) begin
                  state_d = STOP_BIT;
               end
            end
         end
         STOP_BIT: begin
            ctr_d = ctr_q + CTR_SIZE'(1);
            if (ctr_q == CTR_LAST) begin
               ctr_d   = '0;
               state_d = rx_s ? IDLE : WAIT_HIGH;
            end
         end
         WAIT_HIGH: begin
            ctr_d = '0;
            if (rx_s) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d   = IDLE;
            ctr_d     = '0;
            bit_ctr_d = '0;
         end
      endcase
   end

   always_comb begin
      new_data_set  = 1'b0;
      frame_err_set = 1'b0;
      busy          = (state_q != IDLE);
      if (state_q == STOP_BIT && ctr_q == CTR_LAST) begin
         new_data_set  = rx_s;
         frame_err_set = !rx_s;
      end
   end

   assign bus.data      = data_q;
   assign bus.new_data  = new_data_q;
   assign bus.frame_err = frame_err_q;
   assign bus.busy      = busy;

endmodule

// File: tb/tb_serial_rx.sv
// tb/tb_serial_rx.sv - randomized self-checking bench for serial_rx
module tb_serial_rx;
   logic clk;
   logic rst;
   int   total;
   int   bad;

   serial_rx_if bus0();
   serial_rx_if bus1();

   serial_rx #(.CLK_PER_BIT(50)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
   serial_rx #(.CLK_PER_BIT(4))  dut1 (.clk(clk), .rst(rst), .bus(bus1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [7:0] got0[$];
   logic [7:0] got1[$];
   int         fe0, fe1, both;

   always @(negedge clk) begin
      if (bus0.new_data) got0.push_back(bus0.data);
      if (bus1.new_data) got1.push_back(bus1.data);
      if (bus0.frame_err) fe0++;
      if (bus1.frame_err) fe1++;
      if ((bus0.new_data && bus0.frame_err) || (bus1.new_data && bus1.frame_err)) both++;
   end

   // Frame = start(0), 8 data bits LSB first, stop; line returns high afterwards.
   task automatic send_byte(input logic [7:0] b, input int per, input bit stop_ok, input bit sel);
      logic [9:0] frame;
      frame = {stop_ok, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         if (sel) bus1.rx = frame[i]; else bus0.rx = frame[i];
         repeat (per) @(negedge clk);
      end
      if (sel) bus1.rx = 1'b1; else bus0.rx = 1'b1;
   endtask

   task automatic clear_mon();
      got0.delete();
      got1.delete();
      fe0 = 0;
      fe1 = 0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      bus0.rx = 1'b1;
      bus1.rx = 1'b1;
      repeat (3) @(negedge clk);
      total++; if (bus0.data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", bus0.data); end
      total++; if (bus0.new_data !== 1'b0) begin bad++; $display("FAIL reset_new_data got=%b exp=0", bus0.new_data); end
      total++; if (bus0.frame_err !== 1'b0) begin bad++; $display("FAIL reset_frame_err got=%b exp=0", bus0.frame_err); end
      total++; if (bus0.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus0.busy); end
      rst = 1'b1;
      repeat (5) @(negedge clk);
      clear_mon();
   endtask

   task automatic test_basic();
      clear_mon();
      total++; if (bus0.busy !== 1'b0) begin bad++; $display("FAIL basic_busy_idle got=%b exp=0", bus0.busy); end
      fork
         send_byte(8'hA5, 50, 1'b1, 1'b0);
         begin
            repeat (250) @(negedge clk);
            total++; if (bus0.busy !== 1'b1) begin bad++; $display("FAIL basic_busy_mid got=%b exp=1", bus0.busy); end
         end
      join
      repeat (5) @(negedge clk);
      total++; if (got0.size() != 1) begin bad++; $display("FAIL basic_count got=%0d exp=1", got0.size()); end
      else begin
         total++; if (got0[0] !== 8'hA5) begin bad++; $display("FAIL basic_data got=%h exp=a5", got0[0]); end
      end
      total++; if (fe0 != 0) begin bad++; $display("FAIL basic_fe got=%0d exp=0", fe0); end
      total++; if (bus0.busy !== 1'b0) begin bad++; $display("FAIL basic_busy_end got=%b exp=0", bus0.busy); end
   endtask

   task automatic test_glitch();
      clear_mon();
      bus0.rx = 1'b0;
      repeat (10) @(negedge clk);
      bus0.rx = 1'b1;
      repeat (20) @(negedge clk);
      total++; if (bus0.busy !== 1'b0) begin bad++; $display("FAIL glitch_idle busy=%b exp=0", bus0.busy); end
      repeat (50) @(negedge clk);
      total++; if (got0.size() != 0 || fe0 != 0) begin bad++; $display("FAIL glitch_strobe nd=%0d fe=%0d exp=0/0", got0.size(), fe0); end
      total++; if (bus0.data !== 8'hA5) begin bad++; $display("FAIL glitch_data got=%h exp=a5", bus0.data); end
   endtask

   task automatic test_frame_err();
      clear_mon();
      send_byte(8'h3C, 50, 1'b0, 1'b0);
      repeat (10) @(negedge clk);
      total++; if (fe0 != 1) begin bad++; $display("FAIL ferr_count got=%0d exp=1", fe0); end
      total++; if (got0.size() != 0) begin bad++; $display("FAIL ferr_new_data got=%0d exp=0", got0.size()); end
      total++; if (bus0.data !== 8'hA5) begin bad++; $display("FAIL ferr_data got=%h exp=a5", bus0.data); end
   endtask

   task automatic test_break();
      clear_mon();
      bus0.rx = 1'b0;
      repeat (20 * 50) @(negedge clk);
      bus0.rx = 1'b1;
      repeat (10) @(negedge clk);
      total++; if (fe0 != 1) begin bad++; $display("FAIL break_fe got=%0d exp=1", fe0); end
      send_byte(8'h81, 50, 1'b1, 1'b0);
      repeat (5) @(negedge clk);
      total++; if (bus0.data !== 8'h81) begin bad++; $display("FAIL break_data got=%h exp=81", bus0.data); end
      total++; if (got0.size() != 1) begin bad++; $display("FAIL break_count got=%0d exp=1", got0.size()); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] exp[3];
      exp[0] = 8'h00; exp[1] = 8'hFF; exp[2] = 8'h55;
      clear_mon();
      send_byte(exp[0], 50, 1'b1, 1'b0);
      send_byte(exp[1], 50, 1'b1, 1'b0);
      send_byte(exp[2], 52, 1'b1, 1'b0);
      repeat (5) @(negedge clk);
      total++;
      if (got0.size() != 3) begin bad++; $display("FAIL b2b_count got=%0d exp=3", got0.size()); end
      else begin
         for (int i = 0; i < 3; i++) begin
            total++; if (got0[i] !== exp[i]) begin bad++; $display("FAIL b2b_data[%0d] got=%h exp=%h", i, got0[i], exp[i]); end
         end
      end
   endtask

   task automatic test_reset_mid();
      clear_mon();
      fork
         send_byte(8'hC3, 50, 1'b1, 1'b0);
         begin
            repeat (240) @(negedge clk);
            rst = 1'b0;
            #1;
            total++; if (bus0.data !== 8'h00 || bus0.busy !== 1'b0 || bus0.new_data !== 1'b0 || bus0.frame_err !== 1'b0) begin
               bad++; $display("FAIL rstmid_outputs data=%h busy=%b nd=%b fe=%b exp=00/0/0/0", bus0.data, bus0.busy, bus0.new_data, bus0.frame_err);
            end
         end
      join
      repeat (5) @(negedge clk);
      rst = 1'b1;
      repeat (5) @(negedge clk);
      total++; if (got0.size() != 0 || fe0 != 0) begin bad++; $display("FAIL rstmid_strobe nd=%0d fe=%0d exp=0/0", got0.size(), fe0); end
      send_byte(8'h7E, 50, 1'b1, 1'b0);
      repeat (5) @(negedge clk);
      total++; if (bus0.data !== 8'h7E) begin bad++; $display("FAIL rstmid_data got=%h exp=7e", bus0.data); end
   endtask

   task automatic test_small_clk();
      clear_mon();
      send_byte(8'hA5, 4, 1'b1, 1'b1);
      repeat (5) @(negedge clk);
      total++; if (bus1.data !== 8'hA5) begin bad++; $display("FAIL small_data got=%h exp=a5", bus1.data); end
      total++; if (got1.size() != 1 || fe1 != 0) begin bad++; $display("FAIL small_count nd=%0d fe=%0d exp=1/0", got1.size(), fe1); end
   endtask

   task automatic test_random();
      logic [7:0] exp_q[$];
      logic [7:0] last_good;
      logic [7:0] b;
      int         exp_fe;
      bit         ok;
      clear_mon();
      exp_fe    = 0;
      last_good = bus0.data;
      for (int n = 0; n < 20; n++) begin
         b  = 8'($urandom);
         ok = ($urandom_range(0, 3) != 0);
         send_byte(b, $urandom_range(48, 52), ok, 1'b0);
         if (ok) begin
            exp_q.push_back(b);
            last_good = b;
            repeat ($urandom_range(0, 3)) @(negedge clk);
         end else begin
            exp_fe++;
            repeat (10) @(negedge clk);
         end
      end
      repeat (10) @(negedge clk);
      total++;
      if (got0.size() != exp_q.size()) begin bad++; $display("FAIL rand_count got=%0d exp=%0d", got0.size(), exp_q.size()); end
      else begin
         for (int i = 0; i < exp_q.size(); i++) begin
            total++; if (got0[i] !== exp_q[i]) begin bad++; $display("FAIL rand_data[%0d] got=%h exp=%h", i, got0[i], exp_q[i]); end
         end
      end
      total++; if (fe0 != exp_fe) begin bad++; $display("FAIL rand_fe got=%0d exp=%0d", fe0, exp_fe); end
      total++; if (bus0.data !== last_good) begin bad++; $display("FAIL rand_hold got=%h exp=%h", bus0.data, last_good); end
      total++; if (both != 0) begin bad++; $display("FAIL nd_fe_overlap got=%0d exp=0", both); end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      both  = 0;
      fe0   = 0;
      fe1   = 0;
      test_reset();
      test_basic();
      test_glitch();
      test_frame_err();
      test_break();
      test_back_to_back();
      test_reset_mid();
      test_small_clk();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
